bram_arbiter: RTL and testbench
===============================

# bram_arbiter

Two-port round-robin arbiter that shares one 64-entry single-port BRAM (one access per cycle, registered read-first output, 1-cycle read latency) between two requesters: the sample load/unload path (port 0) and the FFT butterfly engine (port 1). It issues at most one access per cycle, returns read data to the issuing requester with a tag, and supports a lock so a requester can hold the memory across a read-modify-write sequence. A lock timeout prevents a stalled owner from starving the other port.

## Interface
- WIDTH, 32, data word width
- ADDR_W, 6, BRAM address width (64 entries)
- LOCK_TIMEOUT, 16, idle cycles tolerated in a locked state before forced release (1..255)

- Clk  in  1  clock, all logic on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Req0_Valid / Req1_Valid  in  1  request present
- Req0_Ready / Req1_Ready  out  1  request accepted this cycle (combinational)
- Req0_We / Req1_We  in  1  1 = write, 0 = read
- Req0_Lock / Req1_Lock  in  1  keep ownership after this transfer
- Req0_Addr / Req1_Addr  in  ADDR_W  word address
- Req0_Wdata / Req1_Wdata  in  WIDTH  write data
- Rsp0_Valid / Rsp1_Valid  out  1  read data valid (one-cycle pulse, no backpressure)
- Rsp_Rdata  out  WIDTH  read data, shared by both ports, qualified by RspN_Valid
- Bram_En  out  1  BRAM enable
- Bram_We  out  1  BRAM write enable
- Bram_Addr  out  ADDR_W  BRAM address
- Bram_DI  out  WIDTH  BRAM write data
- Bram_DO  in  WIDTH  BRAM registered read data
- Lock_Timeout  out  1  one-cycle pulse on forced lock release

## Operation
- States: IDLE, OWN0, OWN1. Reset → IDLE, round-robin pointer Last = 1 (port 0 wins first tie), idle counter 0.
- IDLE: single valid requester is granted. Both valid: grant the port ≠ Last. Grant sets Last = granted port.
- OWNk: only port k can be granted; other port's Ready = 0 regardless of Valid.
- Transfer = ReqN_Valid & ReqN_Ready. On a transfer by port k: if ReqK_Lock = 1 → next state OWNk; if 0 → IDLE.
- Ready is combinational from Valid, state, Last; no dependency of Valid on Ready is permitted from requesters (standard valid/ready; Valid must hold until transfer, Addr/We/Wdata/Lock stable while Valid).
- On transfer: Bram_En = 1, Bram_We = ReqK_We, Bram_Addr/Bram_DI from port k. No transfer: Bram_En = 0, Bram_We = 0, Addr/DI = 0.
- Reads: registered tag (valid, port) captured at the transfer edge; next cycle RspK_Valid = 1 and Rsp_Rdata = Bram_DO. Writes produce no response.
- Lock timeout: in OWNk, counter increments each cycle ReqK_Valid = 0, clears on ReqK_Valid = 1. When counter reaches LOCK_TIMEOUT - 1 and owner still idle: next state IDLE, Last = k, Lock_Timeout pulses the following cycle, counter cleared.
- Same-address write then read: BRAM is read-first; a read issued the cycle after a write returns the new data, a write returns nothing.

## Timing
- Grant/issue: same cycle as Valid (zero-cycle arbitration), throughput one access per cycle.
- Read latency: Rsp valid exactly 1 cycle after the transfer cycle; back-to-back reads give back-to-back responses in issue order.
- Reset values: all Ready 0 while Rst_n low, RspN_Valid 0, Rsp_Rdata 0, Bram_En 0, Bram_We 0, Bram_Addr 0, Bram_DI 0, Lock_Timeout 0.
- Reset asserted mid-operation: pending response tag dropped (no Rsp pulse after reset), lock released, state IDLE.
- Lock request while already owner: ownership continues; last transfer with Lock = 0 releases at that edge, so the other port may be granted the very next cycle.
- Timeout and owner Valid rising in the same cycle: Valid wins (transfer occurs, no timeout).

## Test plan
- Single port: port 0 write addr 5 = 0xDEADBEEF, then read addr 5 → Rsp0_Valid one cycle after read transfer, Rsp_Rdata = 0xDEADBEEF, Rsp1_Valid stays 0.
- Contention: both ports continuously read addr 1 (port 0) and addr 2 (port 1) for 8 cycles after reset → grants alternate 0,1,0,1…, each port gets 4 responses, no idle Bram_En cycle.
- Lock RMW: port 1 read addr 10 with Lock = 1, port 0 valid throughout; port 1 write addr 10 (Lock = 0) two cycles later → Req0_Ready = 0 until after port 1 write, port 0 granted next cycle.
- Timeout: port 0 transfer with Lock = 1 then drops Valid, port 1 valid → after LOCK_TIMEOUT (16) idle cycles Lock_Timeout pulses once, port 1 granted next cycle.
- Reset mid-read: assert Rst_n low in the cycle after a read transfer → Rsp0_Valid/Rsp1_Valid stay 0, all outputs at reset values, after release port 0 wins first tie.
- Write-then-read same cycle sequence: port 1 writes addr 63 = 0x12345678, port 0 reads addr 63 next cycle → Rsp0 data 0x12345678; address wrap: addr 63 and addr 0 independent.

Source files
------------

// File: rtl/bram_arbiter.sv
// ---------------------------------------------------------------------------
// bram_arbiter
// Round-robin arbiter sharing one single-port, read-first BRAM between the
// sample load/unload path (port 0) and the FFT butterfly engine (port 1).
// At most one BRAM access per cycle with zero-cycle arbitration. A requester
// may lock the memory across a read-modify-write. A lock that sits idle for
// LOCK_TIMEOUT cycles is force-released.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   reqN_valid/ready     request handshake (ready is combinational)
//   reqN_we/lock         write select / keep ownership after this transfer
//   reqN_addr/wdata      word address / write data
//   rspN_valid           read response pulse for port N (registered)
//   rsp_rdata            shared read data, zero when no response
//   bram_en/we/addr/di   BRAM request side (combinational from the grant)
//   bram_do              BRAM registered read data
//   lock_timeout         one-cycle pulse after a forced lock release
// ---------------------------------------------------------------------------
module bram_arbiter #(
   parameter int unsigned WIDTH        = 32,
   parameter int unsigned ADDR_W       = 6,
   parameter int unsigned LOCK_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic              req0_we,
   input  logic              req0_lock,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [WIDTH-1:0]  req0_wdata,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              req1_we,
   input  logic              req1_lock,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [WIDTH-1:0]  req1_wdata,
   output logic              rsp0_valid,
   output logic              rsp1_valid,
   output logic [WIDTH-1:0]  rsp_rdata,
   output logic              bram_en,
   output logic              bram_we,
   output logic [ADDR_W-1:0] bram_addr,
   output logic [WIDTH-1:0]  bram_di,
   input  logic [WIDTH-1:0]  bram_do,
   output logic              lock_timeout
);

   localparam int unsigned      CNT_W    = 8;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_OWN0 = 2'd1,
      ST_OWN1 = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             last;          // port granted most recently
   logic             last_nxt;
   logic [CNT_W-1:0] idle_cnt;      // owner-idle cycles while locked
   logic [CNT_W-1:0] idle_cnt_nxt;
   logic             timeout_nxt;
   logic             grant0;
   logic             grant1;

   // State register, round-robin pointer, idle counter and timeout pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         last         <= 1'b1;
         idle_cnt     <= '0;
         lock_timeout <= 1'b0;
      end else begin
         state        <= state_nxt;
         last         <= last_nxt;
         idle_cnt     <= idle_cnt_nxt;
         lock_timeout <= timeout_nxt;
      end
   end

   // Read response tag: captured at the transfer edge, BRAM data lands next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp1_valid <= 1'b0;
      end else begin
         rsp0_valid <= grant0 & ~req0_we;
         rsp1_valid <= grant1 & ~req1_we;
      end
   end

   // Next-state logic: ownership transitions and lock timeout
   always_comb begin
      state_nxt    = state;
      last_nxt     = last;
      idle_cnt_nxt = idle_cnt;
      timeout_nxt  = 1'b0;
      case (state)
         ST_IDLE: begin
            idle_cnt_nxt = '0;
            if (grant0) begin
               last_nxt  = 1'b0;
               state_nxt = req0_lock ? ST_OWN0 : ST_IDLE;
            end else if (grant1) begin
               last_nxt  = 1'b1;
               state_nxt = req1_lock ? ST_OWN1 : ST_IDLE;
            end
         end
         ST_OWN0: begin
            // An owner request in the expiry cycle still wins over the timeout
            if (grant0) begin
               idle_cnt_nxt = '0;
               last_nxt     = 1'b0;
               state_nxt    = req0_lock ? ST_OWN0 : ST_IDLE;
            end else if (idle_cnt == CNT_LAST) begin
               idle_cnt_nxt = '0;
               last_nxt     = 1'b0;
               state_nxt    = ST_IDLE;
               timeout_nxt  = 1'b1;
            end else begin
               idle_cnt_nxt = idle_cnt + CNT_W'(1);
            end
         end
         ST_OWN1: begin
            if (grant1) begin
               idle_cnt_nxt = '0;
               last_nxt     = 1'b1;
               state_nxt    = req1_lock ? ST_OWN1 : ST_IDLE;
            end else if (idle_cnt == CNT_LAST) begin
               idle_cnt_nxt = '0;
               last_nxt     = 1'b1;
               state_nxt    = ST_IDLE;
               timeout_nxt  = 1'b1;
            end else begin
               idle_cnt_nxt = idle_cnt + CNT_W'(1);
            end
         end
         default: begin
            state_nxt    = ST_IDLE;
            idle_cnt_nxt = '0;
         end
      endcase
   end

   // Output logic: grant selection, ready and BRAM request mux
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      case (state)
         ST_IDLE: begin
            // Tie goes to the port that did not win last time
            if (req0_valid && (!req1_valid || last)) begin
               grant0 = 1'b1;
            end else if (req1_valid) begin
               grant1 = 1'b1;
            end
         end
         ST_OWN0: grant0 = req0_valid;
         ST_OWN1: grant1 = req1_valid;
         default: begin
            grant0 = 1'b0;
            grant1 = 1'b0;
         end
      endcase
      if (!rst_n) begin
         grant0 = 1'b0;
         grant1 = 1'b0;
      end

      req0_ready = grant0;
      req1_ready = grant1;

      bram_en   = grant0 | grant1;
      bram_we   = 1'b0;
      bram_addr = '0;
      bram_di   = '0;
      if (grant0) begin
         bram_we   = req0_we;
         bram_addr = req0_addr;
         bram_di   = req0_wdata;
      end else if (grant1) begin
         bram_we   = req1_we;
         bram_addr = req1_addr;
         bram_di   = req1_wdata;
      end
   end

   // Shared read data is only driven while a response is being returned
   always_comb begin
      rsp_rdata = '0;
      if (rsp0_valid || rsp1_valid) begin
         rsp_rdata = bram_do;
      end
   end

endmodule

// File: tb/tb_bram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_arbiter
// Self-checking bench for bram_arbiter: directed scenarios followed by a
// randomized run checked against a transaction-level arbitration model with a
// golden memory image. The BRAM itself is a bench-side read-first array.
// ---------------------------------------------------------------------------
module tb_bram_arbiter;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned ADDR_W = 6;
   localparam int unsigned LT     = 16;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              req0_valid, req0_we, req0_lock;
   logic [ADDR_W-1:0] req0_addr;
   logic [WIDTH-1:0]  req0_wdata;
   logic              req1_valid, req1_we, req1_lock;
   logic [ADDR_W-1:0] req1_addr;
   logic [WIDTH-1:0]  req1_wdata;
   logic              req0_ready, req1_ready;
   logic              rsp0_valid, rsp1_valid;
   logic [WIDTH-1:0]  rsp_rdata;
   logic              bram_en, bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [WIDTH-1:0]  bram_di;
   logic [WIDTH-1:0]  bram_do;
   logic              lock_timeout;

   int total = 0;
   int bad   = 0;

   bram_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LOCK_TIMEOUT(LT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
      .req0_lock(req0_lock), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
      .req1_lock(req1_lock), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
      .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
      .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
      .bram_di(bram_di), .bram_do(bram_do), .lock_timeout(lock_timeout)
   );

   always #5 clk = ~clk;

   // Single-port read-first BRAM with registered output
   logic [WIDTH-1:0] mem [64];
   always @(posedge clk) begin
      if (bram_en) begin
         bram_do <= mem[bram_addr];
         if (bram_we) mem[bram_addr] <= bram_di;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic we, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = a; req0_wdata = d;
   endtask

   task automatic drive1(input logic v, input logic we, input logic lk,
                         input logic [ADDR_W-1:0] a, input logic [WIDTH-1:0] d);
      req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = a; req1_wdata = d;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      drive0(1'b1, 1'b1, 1'b1, 6'd7, 32'h1111_2222);
      drive1(1'b1, 1'b1, 1'b1, 6'd9, 32'h3333_4444);
      step();
      step();
      total += 10;
      if (req0_ready !== 1'b0) begin bad++; $display("FAIL reset_ready0 got=%b exp=0", req0_ready); end
      if (req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready1 got=%b exp=0", req1_ready); end
      if (bram_en !== 1'b0) begin bad++; $display("FAIL reset_bram_en got=%b exp=0", bram_en); end
      if (bram_we !== 1'b0) begin bad++; $display("FAIL reset_bram_we got=%b exp=0", bram_we); end
      if (bram_addr !== 6'd0) begin bad++; $display("FAIL reset_bram_addr got=%0d exp=0", bram_addr); end
      if (bram_di !== 32'h0) begin bad++; $display("FAIL reset_bram_di got=%h exp=0", bram_di); end
      if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp0 got=%b exp=0", rsp0_valid); end
      if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp1 got=%b exp=0", rsp1_valid); end
      if (rsp_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
      if (lock_timeout !== 1'b0) begin bad++; $display("FAIL reset_timeout got=%b exp=0", lock_timeout); end
      do_reset();
   endtask

   task automatic test_single_port();
      drive0(1'b1, 1'b1, 1'b0, 6'd5, 32'hDEAD_BEEF);
      #1;
      total += 4;
      if (req0_ready !== 1'b1) begin bad++; $display("FAIL single_wr_ready got=%b exp=1", req0_ready); end
      if (bram_we !== 1'b1 || bram_en !== 1'b1) begin bad++; $display("FAIL single_wr_en got=%b%b exp=11", bram_en, bram_we); end
      if (bram_addr !== 6'd5) begin bad++; $display("FAIL single_wr_addr got=%0d exp=5", bram_addr); end
      if (bram_di !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_wr_di got=%h exp=deadbeef", bram_di); end
      step();
      drive0(1'b1, 1'b0, 1'b0, 6'd5, 32'h0);
      #1;
      total += 2;
      if (req0_ready !== 1'b1 || bram_we !== 1'b0) begin bad++; $display("FAIL single_rd_issue got=%b%b exp=10", req0_ready, bram_we); end
      if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_wr_norsp got=%b exp=0", rsp0_valid); end
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 3;
      if (rsp0_valid !== 1'b1) begin bad++; $display("FAIL single_rsp0 got=%b exp=1", rsp0_valid); end
      if (rsp_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rsp_rdata); end
      if (rsp1_valid !== 1'b0) begin bad++; $display("FAIL single_rsp1 got=%b exp=0", rsp1_valid); end
      step();
      total += 1;
      if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL single_rsp_pulse got=%b exp=0", rsp0_valid); end
   endtask

   task automatic test_wrap();
      drive1(1'b1, 1'b1, 1'b0, 6'd63, 32'h1234_5678);
      step();
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive0(1'b1, 1'b0, 1'b0, 6'd63, 32'h0);
      #1;
      total += 1;
      if (req0_ready !== 1'b1) begin bad++; $display("FAIL wrap_ready got=%b exp=1", req0_ready); end
      step();
      drive0(1'b1, 1'b1, 1'b0, 6'd0, 32'hA5A5_A5A5);
      #1;
      total += 1;
      if (rsp0_valid !== 1'b1 || rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wrap_rd63 got=%b/%h exp=1/12345678", rsp0_valid, rsp_rdata); end
      step();
      drive0(1'b1, 1'b0, 1'b0, 6'd63, 32'h0);
      step();
      drive0(1'b1, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 1;
      if (rsp_rdata !== 32'h1234_5678) begin bad++; $display("FAIL wrap_rd63_again got=%h exp=12345678", rsp_rdata); end
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 1;
      if (rsp0_valid !== 1'b1 || rsp_rdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL wrap_rd0 got=%b/%h exp=1/a5a5a5a5", rsp0_valid, rsp_rdata); end
      step();
   endtask

   task automatic test_contention();
      int n0 = 0;
      int n1 = 0;
      drive0(1'b1, 1'b1, 1'b0, 6'd1, 32'hAAAA_0001);
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b1, 1'b1, 1'b0, 6'd2, 32'hBBBB_0002);
      step();
      do_reset();
      drive0(1'b1, 1'b0, 1'b0, 6'd1, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, 6'd2, 32'h0);
      for (int i = 0; i < 9; i++) begin
         if (i == 8) begin
            drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
            drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
         end
         #1;
         if (i < 8) begin
            total += 2;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
               bad++; $display("FAIL cont_grant cyc=%0d got=%b%b exp0=%b", i, req0_ready, req1_ready, (i % 2 == 0));
            end
            if (bram_en !== 1'b1) begin bad++; $display("FAIL cont_bram_en cyc=%0d got=%b exp=1", i, bram_en); end
         end
         if (rsp0_valid === 1'b1) n0++;
         if (rsp1_valid === 1'b1) n1++;
         if (i > 0) begin
            total += 2;
            if (rsp0_valid !== ((i - 1) % 2 == 0) || rsp1_valid !== ((i - 1) % 2 == 1)) begin
               bad++; $display("FAIL cont_rsp cyc=%0d got=%b%b", i, rsp0_valid, rsp1_valid);
            end
            if (rsp_rdata !== (((i - 1) % 2 == 0) ? 32'hAAAA_0001 : 32'hBBBB_0002)) begin
               bad++; $display("FAIL cont_rdata cyc=%0d got=%h", i, rsp_rdata);
            end
         end
         step();
      end
      total += 1;
      if (n0 != 4 || n1 != 4) begin bad++; $display("FAIL cont_count got=%0d/%0d exp=4/4", n0, n1); end
   endtask

   task automatic test_lock_rmw();
      do_reset();
      drive1(1'b1, 1'b1, 1'b0, 6'd10, 32'h0A0A_0A0A);
      step();
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive0(1'b1, 1'b1, 1'b0, 6'd21, 32'h2121_2121);
      step();
      // port 0 won last, so port 1 wins the tie and locks
      drive0(1'b1, 1'b0, 1'b0, 6'd21, 32'h0);
      drive1(1'b1, 1'b0, 1'b1, 6'd10, 32'h0);
      #1;
      total += 2;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin bad++; $display("FAIL rmw_grant1 got=%b%b exp=01", req0_ready, req1_ready); end
      if (bram_addr !== 6'd10) begin bad++; $display("FAIL rmw_addr got=%0d exp=10", bram_addr); end
      step();
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 3;
      if (req0_ready !== 1'b0 || bram_en !== 1'b0) begin bad++; $display("FAIL rmw_hold got=%b%b exp=00", req0_ready, bram_en); end
      if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin bad++; $display("FAIL rmw_rsp1 got=%b%b exp=01", rsp0_valid, rsp1_valid); end
      if (rsp_rdata !== 32'h0A0A_0A0A) begin bad++; $display("FAIL rmw_rdata got=%h exp=0a0a0a0a", rsp_rdata); end
      step();
      drive1(1'b1, 1'b1, 1'b0, 6'd10, 32'h0A0A_0A0B);
      #1;
      total += 1;
      if (req1_ready !== 1'b1 || req0_ready !== 1'b0 || bram_we !== 1'b1) begin bad++; $display("FAIL rmw_write got=%b%b%b exp=011", req0_ready, req1_ready, bram_we); end
      step();
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 1;
      if (req0_ready !== 1'b1 || bram_addr !== 6'd21) begin bad++; $display("FAIL rmw_release got=%b/%0d exp=1/21", req0_ready, bram_addr); end
      step();
      drive0(1'b1, 1'b0, 1'b0, 6'd10, 32'h0);
      #1;
      total += 1;
      if (rsp0_valid !== 1'b1 || rsp_rdata !== 32'h2121_2121) begin bad++; $display("FAIL rmw_rsp0 got=%b/%h exp=1/21212121", rsp0_valid, rsp_rdata); end
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 1;
      if (rsp_rdata !== 32'h0A0A_0A0B) begin bad++; $display("FAIL rmw_result got=%h exp=0a0a0a0b", rsp_rdata); end
      step();
   endtask

   task automatic test_timeout();
      do_reset();
      drive0(1'b1, 1'b0, 1'b1, 6'd3, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, 6'd4, 32'h0);
      #1;
      total += 1;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL to_lock got=%b%b exp=10", req0_ready, req1_ready); end
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      for (int k = 1; k <= int'(LT); k++) begin
         #1;
         total += 1;
         if (req1_ready !== 1'b0 || lock_timeout !== 1'b0) begin
            bad++; $display("FAIL to_wait idle=%0d got=%b%b exp=00", k, req1_ready, lock_timeout);
         end
         step();
      end
      #1;
      total += 1;
      if (lock_timeout !== 1'b1 || req1_ready !== 1'b1) begin bad++; $display("FAIL to_fire got=%b%b exp=11", lock_timeout, req1_ready); end
      step();
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 1;
      if (lock_timeout !== 1'b0) begin bad++; $display("FAIL to_pulse got=%b exp=0", lock_timeout); end
      step();
   endtask

   task automatic test_timeout_valid_wins();
      do_reset();
      drive0(1'b1, 1'b0, 1'b1, 6'd3, 32'h0);
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, 6'd4, 32'h0);
      for (int k = 1; k < int'(LT); k++) step();
      drive0(1'b1, 1'b0, 1'b0, 6'd3, 32'h0);
      #1;
      total += 1;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL vw_owner got=%b%b exp=10", req0_ready, req1_ready); end
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 1;
      if (lock_timeout !== 1'b0 || req1_ready !== 1'b1) begin bad++; $display("FAIL vw_notimeout got=%b%b exp=01", lock_timeout, req1_ready); end
      step();
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      step();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      drive0(1'b1, 1'b0, 1'b0, 6'd5, 32'h0);
      step();
      rst_n = 1'b0;
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      #1;
      total += 2;
      if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin bad++; $display("FAIL rmid_rsp got=%b%b exp=00", rsp0_valid, rsp1_valid); end
      if (rsp_rdata !== 32'h0 || bram_en !== 1'b0 || lock_timeout !== 1'b0) begin bad++; $display("FAIL rmid_outs got=%h/%b/%b", rsp_rdata, bram_en, lock_timeout); end
      step();
      rst_n = 1'b1;
      drive0(1'b1, 1'b0, 1'b0, 6'd1, 32'h0);
      drive1(1'b1, 1'b0, 1'b0, 6'd2, 32'h0);
      #1;
      total += 2;
      if (rsp0_valid !== 1'b0) begin bad++; $display("FAIL rmid_norsp got=%b exp=0", rsp0_valid); end
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL rmid_tie got=%b%b exp=10", req0_ready, req1_ready); end
      step();
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      step();
   endtask

   // Randomized traffic against a transaction-level model of the arbiter
   task automatic test_random();
      logic             pend [2];
      logic             p_we [2];
      logic             p_lk [2];
      logic [ADDR_W-1:0] p_ad [2];
      logic [WIDTH-1:0] p_dt [2];
      int               act [2];
      logic [WIDTH-1:0] gm [64];
      logic             known [64];
      int owner = -1;
      int last = 1;
      int idle = 0;
      int exp_rp = -1;
      logic [WIDTH-1:0] exp_data = '0;
      logic exp_known = 1'b0;
      logic exp_to = 1'b0;
      int timeouts = 0;
      int g;
      for (int i = 0; i < 64; i++) begin gm[i] = '0; known[i] = 1'b0; end
      for (int p = 0; p < 2; p++) begin
         pend[p] = 1'b0; p_we[p] = 1'b0; p_lk[p] = 1'b0; p_ad[p] = '0; p_dt[p] = '0; act[p] = 50;
      end
      do_reset();
      for (int cyc = 0; cyc < 800; cyc++) begin
         if (cyc % 40 == 0) begin
            for (int p = 0; p < 2; p++) begin
               case ($urandom_range(0, 2))
                  0:       act[p] = 0;
                  1:       act[p] = 30;
                  default: act[p] = 90;
               endcase
            end
         end
         for (int p = 0; p < 2; p++) begin
            if (!pend[p] && int'($urandom_range(0, 99)) < act[p]) begin
               pend[p] = 1'b1;
               p_we[p] = 1'($urandom_range(0, 1));
               p_lk[p] = ($urandom_range(0, 3) == 0);
               p_ad[p] = ADDR_W'($urandom_range(0, 63));
               p_dt[p] = $urandom;
            end
         end
         drive0(pend[0], p_we[0], p_lk[0], p_ad[0], p_dt[0]);
         drive1(pend[1], p_we[1], p_lk[1], p_ad[1], p_dt[1]);
         #1;
         if (owner < 0) g = (pend[0] && (!pend[1] || last == 1)) ? 0 : (pend[1] ? 1 : -1);
         else           g = pend[owner] ? owner : -1;

         total += 5;
         if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
            bad++; $display("FAIL rnd_ready cyc=%0d got=%b%b exp_grant=%0d", cyc, req0_ready, req1_ready, g);
         end
         if (bram_en !== (g >= 0)) begin bad++; $display("FAIL rnd_en cyc=%0d got=%b exp=%b", cyc, bram_en, (g >= 0)); end
         if (g >= 0) begin
            if (bram_we !== p_we[g] || bram_addr !== p_ad[g] || bram_di !== p_dt[g]) begin
               bad++; $display("FAIL rnd_bram cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", cyc, bram_we, bram_addr, bram_di, p_we[g], p_ad[g], p_dt[g]);
            end
         end else if (bram_we !== 1'b0 || bram_addr !== '0 || bram_di !== '0) begin
            bad++; $display("FAIL rnd_bram_idle cyc=%0d got=%b/%0d/%h exp=0", cyc, bram_we, bram_addr, bram_di);
         end
         if (rsp0_valid !== (exp_rp == 0) || rsp1_valid !== (exp_rp == 1)) begin
            bad++; $display("FAIL rnd_rsp cyc=%0d got=%b%b exp_port=%0d", cyc, rsp0_valid, rsp1_valid, exp_rp);
         end
         if (lock_timeout !== exp_to) begin bad++; $display("FAIL rnd_timeout cyc=%0d got=%b exp=%b", cyc, lock_timeout, exp_to); end
         if (exp_rp < 0) begin
            total += 1;
            if (rsp_rdata !== '0) begin bad++; $display("FAIL rnd_rdata_idle cyc=%0d got=%h exp=0", cyc, rsp_rdata); end
         end else if (exp_known) begin
            total += 1;
            if (rsp_rdata !== exp_data) begin bad++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", cyc, rsp_rdata, exp_data); end
         end

         exp_rp = -1;
         exp_to = 1'b0;
         if (g >= 0) begin
            if (p_we[g]) begin
               gm[p_ad[g]] = p_dt[g];
               known[p_ad[g]] = 1'b1;
            end else begin
               exp_rp = g;
               exp_data = gm[p_ad[g]];
               exp_known = known[p_ad[g]];
            end
            last = g;
            owner = p_lk[g] ? g : -1;
            idle = 0;
            pend[g] = 1'b0;
         end else if (owner >= 0) begin
            if (idle == int'(LT) - 1) begin
               last = owner;
               owner = -1;
               idle = 0;
               exp_to = 1'b1;
               timeouts++;
            end else begin
               idle++;
            end
         end
         step();
      end
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      step();
      step();
      $display("random run: forced releases=%0d", timeouts);
   endtask

   initial begin
      drive0(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      drive1(1'b0, 1'b0, 1'b0, 6'd0, 32'h0);
      test_reset();
      test_single_port();
      test_wrap();
      test_contention();
      test_lock_rmw();
      test_timeout();
      test_timeout_valid_wins();
      test_reset_mid_read();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
